// File: rtl/scan_decoder_pkg.sv
// Shared types and default sizing for the scan_decoder block.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_e;

    localparam int DEF_SEL_W   = 3;
    localparam int DEF_DWELL_W = 8;

endpackage

// File: rtl/onehot_dec.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder.
module onehot_dec #(
    parameter int SEL_W = 3,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct-hold and auto-scan modes.
// Define SCAN_DECODER_ACTIVE_LOW_EN to drive `out` active-low.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W   = DEF_SEL_W,
    parameter int DWELL_W = DEF_DWELL_W,
    localparam int OUT_W  = 2**SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               en,
    output logic [OUT_W-1:0]   out,
    output logic [SEL_W-1:0]   out_idx,
    output logic               out_valid,
    output logic               wrap
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0]   dec_q, dec_d, dec_w;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic               accept;

    assign in_ready = (state_q != SCAN) && !rst;
    assign accept   = in_valid && in_ready;

    // Decode the next index so the registered pattern lines up with out_idx.
    onehot_dec #(.SEL_W(SEL_W)) u_dec (
        .sel    (idx_d),
        .onehot (dec_w)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;

        if (accept) begin
            idx_d   = in_sel;
            cnt_d   = '0;
            state_d = mode ? SCAN : HOLD;
        end else if (state_q == SCAN) begin
            if (!mode) begin
                state_d = HOLD;
            end else if (en) begin
                if (cnt_q >= dwell) begin
                    cnt_d  = '0;
                    idx_d  = idx_q + SEL_W'(1);
                    wrap_d = (idx_q == '1);
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
        end

        valid_d = en && (state_d != IDLE);
        dec_d   = valid_d ? dec_w : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            dec_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
    assign out = ~dec_q;
`else
    assign out = dec_q;
`endif
    assign out_idx   = idx_q;
    assign out_valid = valid_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_scan_decoder;

    localparam int SEL_W   = 3;
    localparam int DWELL_W = 8;
    localparam int OUT_W   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   in_sel;
    logic               mode;
    logic [DWELL_W-1:0] dwell;
    logic               en;
    logic [OUT_W-1:0]   out;
    logic [SEL_W-1:0]   out_idx;
    logic               out_valid;
    logic               wrap;

    int errors = 0;
    int checks = 0;

    scan_decoder #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .mode      (mode),
        .dwell     (dwell),
        .en        (en),
        .out       (out),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] pat(input logic [OUT_W-1:0] v);
`ifdef SCAN_DECODER_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    // Behavioural model: is anything held, is it scanning, which index, how long dwelt.
    bit m_live     = 0;
    bit m_active   = 0;
    bit m_scanning = 0;
    bit m_shown    = 0;
    bit m_wrap     = 0;
    int m_idx      = 0;
    int m_cnt      = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1; m_active = 0; m_scanning = 0; m_shown = 0;
            m_wrap = 0; m_idx = 0; m_cnt = 0;
        end else if (m_live) begin
            m_wrap = 0;
            if (in_valid && !m_scanning) begin
                m_idx = int'(in_sel);
                m_cnt = 0;
                m_active = 1;
                m_scanning = mode;
            end else if (m_scanning) begin
                if (!mode) m_scanning = 0;
                else if (en) begin
                    if (m_cnt >= int'(dwell)) begin
                        m_cnt  = 0;
                        m_wrap = (m_idx == OUT_W - 1);
                        m_idx  = (m_idx + 1) % OUT_W;
                    end else begin
                        m_cnt++;
                    end
                end
            end
            m_shown = en && m_active;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("out", out, pat(m_shown ? OUT_W'(1 << m_idx) : '0));
            check("out_idx", out_idx, m_idx);
            check("out_valid", out_valid, m_shown);
            check("wrap", wrap, m_wrap);
            check("in_ready", in_ready, !rst && !m_scanning);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int exp_idx[7]  = '{6, 6, 6, 7, 7, 7, 0};
    int exp_wrap[7] = '{0, 0, 0, 0, 0, 0, 1};
    bit found;

    initial begin
        rst = 1; in_valid = 0; in_sel = '0; mode = 0; dwell = '0; en = 1;
        #1;
        check("lit_ready_in_rst", in_ready, 0);
        tick(); tick();
        check("lit_rst_out", out, pat(8'h00));
        check("lit_rst_valid", out_valid, 0);
        check("lit_rst_ready", in_ready, 0);
        rst = 0;
        #1;
        check("lit_idle_ready", in_ready, 1);

        // Direct hold, then replacement without blanking
        in_sel = 3'd5; mode = 0; in_valid = 1;
        tick(); in_valid = 0;
        check("lit_direct5_out", out, pat(8'b0010_0000));
        check("lit_direct5_idx", out_idx, 5);
        check("lit_direct5_valid", out_valid, 1);
        in_sel = 3'd1; in_valid = 1;
        tick(); in_valid = 0;
        check("lit_direct1_out", out, pat(8'b0000_0010));
        check("lit_direct1_valid", out_valid, 1);

        // Scan from 6 with dwell 2 through the wrap
        in_sel = 3'd6; mode = 1; dwell = 8'd2; in_valid = 1;
        tick(); in_valid = 0;
        for (int k = 0; k < 7; k++) begin
            check("lit_scan_idx", out_idx, exp_idx[k]);
            check("lit_scan_wrap", wrap, exp_wrap[k]);
            check("lit_scan_ready", in_ready, 0);
            tick();
        end
        check("lit_wrap_clear", wrap, 0);
        check("lit_after_wrap_idx", out_idx, 0);

        // Blank mid-dwell, then finish the remaining count
        en = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("lit_blank_out", out, pat(8'h00));
            check("lit_blank_valid", out_valid, 0);
        end
        en = 1;
        tick();
        check("lit_resume_idx", out_idx, 0);
        check("lit_resume_out", out, pat(8'h01));
        tick();
        check("lit_resume_adv", out_idx, 1);

        // Leave scan at index 3
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (out_idx == 3'd3) found = 1;
            else tick();
        end
        check("lit_reach_idx3", found, 1);
        mode = 0;
        tick();
        check("lit_exit_idx", out_idx, 3);
        check("lit_exit_ready", in_ready, 1);
        check("lit_exit_out", out, pat(8'h08));

        // Reset mid-scan
        in_sel = 3'd0; mode = 1; dwell = 8'd0; in_valid = 1;
        tick(); in_valid = 0;
        tick(); tick();
        rst = 1;
        tick();
        check("lit_midrst_out", out, pat(8'h00));
        check("lit_midrst_idx", out_idx, 0);
        check("lit_midrst_valid", out_valid, 0);
        check("lit_midrst_wrap", wrap, 0);
        check("lit_midrst_ready", in_ready, 0);
        rst = 0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            in_valid = ($urandom_range(0, 2) == 0);
            in_sel   = SEL_W'($urandom_range(0, OUT_W - 1));
            mode     = ($urandom_range(0, 9) != 0);
            dwell    = ($urandom_range(0, 9) == 0) ? DWELL_W'($urandom_range(4, 12))
                                                   : DWELL_W'($urandom_range(0, 3));
            en       = ($urandom_range(0, 7) != 0);
            tick();
        end
        rst = 0; in_valid = 0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 3, select width; localparam OUT_W = 2**SEL_W.
REQ-002 SHALL have parameter DWELL_W, default 8, dwell counter width.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  select request valid.
REQ-006 in_ready  out  1  block accepts a request this cycle.
REQ-007 in_sel  in  SEL_W  index to decode (the scan start index in scan mode).
REQ-008 mode  in  1  0 = direct hold, 1 = auto-scan.
REQ-009 dwell  in  DWELL_W  scan hold is dwell+1 cycles per index.
REQ-010 en  in  1  output enable; 0 = blank.
REQ-011 out  out  OUT_W  registered one-hot decode.
REQ-012 out_idx  out  SEL_W  index currently decoded.
REQ-013 out_valid  out  1  out carries a live decode.
REQ-014 wrap  out  1  one-cycle pulse when the scan index wraps from OUT_W-1 to 0.

Function
REQ-015 SHALL implement FSM states IDLE, HOLD, SCAN.
REQ-016 in_ready SHALL be 1 in IDLE and HOLD, 0 in SCAN, and 0 while rst=1.
REQ-017 Accept SHALL occur when in_valid&&in_ready; out_idx=in_sel and out=1<<in_sel take effect on the next edge (latency 1).
REQ-018 Accept with mode=0 SHALL go to HOLD; accept with mode=1 SHALL go to SCAN with dwell counter cleared.
REQ-019 An accept in HOLD SHALL replace the index; the last accept wins. No output glitch to zero SHALL occur.
REQ-020 In SCAN, the counter SHALL increment each enabled cycle; on reaching dwell, out_idx SHALL advance by 1 and the counter SHALL clear.
REQ-021 Advance from OUT_W-1 SHALL wrap to 0 and assert wrap for exactly that cycle. Otherwise wrap SHALL be 0.
REQ-022 dwell=0 SHALL advance every cycle. dwell SHALL be sampled live, compared against the counter with >=.
REQ-023 mode=0 while in SCAN SHALL move to HOLD on the next edge, keeping the current out_idx.
REQ-024 en=0 SHALL force out=0 and out_valid=0 and freeze the counter and index. en=1 SHALL resume at the same index and count.
REQ-025 out_valid SHALL be 1 in HOLD or SCAN with en=1; 0 in IDLE.
REQ-026 in_valid SHALL be ignored when in_ready=0; no request is queued.

Reset
REQ-027 rst SHALL set state=IDLE, out=0, out_idx=0, counter=0, wrap=0, out_valid=0 on the next edge.
REQ-028 rst SHALL override every other input in any state, including mid-scan.

Configuration
REQ-029 Macro SCAN_DECODER_ACTIVE_LOW_EN defined: out SHALL be bitwise inverted, giving all-ones at reset, when blank and in IDLE, with the active bit 0.
REQ-030 Macro undefined: out SHALL be active-high as in REQ-017. Other outputs SHALL be unaffected either way.

Structure
REQ-031 Package scan_decoder_pkg SHALL hold the state typedef (IDLE/HOLD/SCAN) and the default parameter constants.
REQ-032 Sub-module onehot_dec SHALL provide the combinational SEL_W-to-OUT_W decode. It is instantiated once, and its output is registered in scan_decoder.

Verification (SEL_W=3)
REQ-033 Reset: hold rst for 2 cycles -> out=8'h00, out_valid=0, in_ready=0. After release: in_ready=1, state IDLE.
REQ-034 Direct: in_sel=5, mode=0, in_valid pulse -> next cycle out=8'b0010_0000, out_idx=5, out_valid=1. Then in_sel=1 -> out=8'b0000_0010.
REQ-035 Scan: in_sel=6, mode=1, dwell=2 -> idx 6 for 3 cycles, then 7 for 3, then 0 with wrap=1 for 1 cycle. in_ready=0 throughout.
REQ-036 Blank: en=0 for 4 cycles mid-dwell in SCAN -> out=0, out_valid=0. After en=1, the same index completes the remaining dwell count.
REQ-037 Exit/reset: drop mode at idx 3 -> HOLD at idx 3 with in_ready=1. Separately, rst mid-scan -> all outputs reset on the next edge.
REQ-038 With SCAN_DECODER_ACTIVE_LOW_EN: reset -> out=8'hFF. Accept in_sel=2 -> out=8'hFB.
